mem_access_unit: RTL and testbench

Load/store initiator that sits between the CPU execute stage and the byte-banked Data_memory. It accepts one request at a time over a valid/ready handshake and drives the memory's Address, Write_data, MemWrite and MemRead strobes. It captures Read_data and returns sign- or zero-extended results. Halfword accesses are sequenced as two byte accesses, and out-of-range addresses are rejected.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and the byte-banked Data_memory.
// Halfword accesses are split into two little-endian byte accesses.
module mem_access_unit #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic [2:0]  Req_op,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    output logic        Rsp_valid,
    output logic [31:0] Rsp_data,
    output logic        Rsp_err,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_Write_data,
    output logic [1:0]  Mem_MemWrite,
    output logic [1:0]  Mem_MemRead,
    input  logic [31:0] Mem_Read_data
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;
    typedef enum logic [2:0] {
        OP_LW  = 3'b000, OP_LB  = 3'b001, OP_LBU = 3'b010, OP_LH = 3'b011,
        OP_LHU = 3'b100, OP_SW  = 3'b101, OP_SB  = 3'b110, OP_SH = 3'b111
    } op_e;
    typedef enum logic [1:0] {STB_NONE = 2'b00, STB_WORD = 2'b01, STB_BYTE = 2'b10} strobe_e;

    localparam logic [32:0] DEPTH_W = 33'(DEPTH);

    function automatic logic is_half(op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_load(op_e op);
        return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
    endfunction

    state_e      state_q;
    op_e         op_q;
    logic [31:0] addr_q;
    logic [7:0]  whi_q;
    logic [7:0]  lo_q;

    op_e     req_op;
    strobe_e req_stb;
    logic    req_in_range;

    // Halfword range check uses 33 bits so addr=0xFFFFFFFF cannot wrap into range.
    always_comb begin
        req_op  = op_e'(Req_op);
        req_stb = is_word(req_op) ? STB_WORD : STB_BYTE;
        if (is_half(req_op))
            req_in_range = ({1'b0, Req_addr} + 33'd1) < DEPTH_W;
        else
            req_in_range = {1'b0, Req_addr} < DEPTH_W;
    end

    assign Req_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= OP_LW;
            addr_q         <= '0;
            whi_q          <= '0;
            lo_q           <= '0;
            Rsp_valid      <= 1'b0;
            Rsp_data       <= '0;
            Rsp_err        <= 1'b0;
            Mem_Address    <= '0;
            Mem_Write_data <= '0;
            Mem_MemWrite   <= STB_NONE;
            Mem_MemRead    <= STB_NONE;
        end else begin
            Rsp_valid <= 1'b0;
            Rsp_data  <= '0;
            Rsp_err   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Req_valid) begin
                        op_q   <= req_op;
                        addr_q <= Req_addr;
                        whi_q  <= Req_wdata[15:8];
                        if (req_in_range) begin
                            state_q     <= ACC0;
                            Mem_Address <= Req_addr;
                            if (is_load(req_op)) begin
                                Mem_MemRead <= req_stb;
                            end else begin
                                Mem_MemWrite   <= req_stb;
                                Mem_Write_data <= is_word(req_op) ? Req_wdata
                                                                  : {24'h0, Req_wdata[7:0]};
                            end
                        end else begin
                            state_q   <= RESP;
                            Rsp_valid <= 1'b1;
                            Rsp_err   <= 1'b1;
                        end
                    end
                end
                ACC0: begin
                    lo_q <= Mem_Read_data[7:0];
                    if (is_half(op_q)) begin
                        state_q     <= ACC1;
                        Mem_Address <= addr_q + 32'd1;
                        if (!is_load(op_q))
                            Mem_Write_data <= {24'h0, whi_q};
                    end else begin
                        state_q        <= RESP;
                        Rsp_valid      <= 1'b1;
                        Mem_Address    <= '0;
                        Mem_Write_data <= '0;
                        Mem_MemWrite   <= STB_NONE;
                        Mem_MemRead    <= STB_NONE;
                        case (op_q)
                            OP_LW:   Rsp_data <= Mem_Read_data;
                            OP_LB:   Rsp_data <= {{24{Mem_Read_data[7]}}, Mem_Read_data[7:0]};
                            OP_LBU:  Rsp_data <= {24'h0, Mem_Read_data[7:0]};
                            default: Rsp_data <= '0;
                        endcase
                    end
                end
                ACC1: begin
                    state_q        <= RESP;
                    Rsp_valid      <= 1'b1;
                    Mem_Address    <= '0;
                    Mem_Write_data <= '0;
                    Mem_MemWrite   <= STB_NONE;
                    Mem_MemRead    <= STB_NONE;
                    case (op_q)
                        OP_LH:   Rsp_data <= {{16{Mem_Read_data[7]}}, Mem_Read_data[7:0], lo_q};
                        OP_LHU:  Rsp_data <= {16'h0, Mem_Read_data[7:0], lo_q};
                        default: Rsp_data <= '0;
                    endcase
                end
                RESP: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-banked memory model
// (negedge write, combinational read).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req_valid, Req_ready;
    logic [2:0]  Req_op;
    logic [31:0] Req_addr, Req_wdata;
    logic        Rsp_valid, Rsp_err;
    logic [31:0] Rsp_data;
    logic [31:0] Mem_Address, Mem_Write_data, Mem_Read_data;
    logic [1:0]  Mem_MemWrite, Mem_MemRead;

    localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011,
                           LHU = 3'b100, SW = 3'b101, SB = 3'b110, SH = 3'b111;

    mem_access_unit #(.DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_op(Req_op),
        .Req_addr(Req_addr), .Req_wdata(Req_wdata),
        .Rsp_valid(Rsp_valid), .Rsp_data(Rsp_data), .Rsp_err(Rsp_err),
        .Mem_Address(Mem_Address), .Mem_Write_data(Mem_Write_data),
        .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
        .Mem_Read_data(Mem_Read_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [7:0] mem3 [256];
    logic [7:0] ma;
    assign ma = Mem_Address[7:0];

    always @(negedge clk) begin
        if (Mem_MemWrite == 2'b01) begin
            mem0[ma] <= Mem_Write_data[7:0];
            mem1[ma] <= Mem_Write_data[15:8];
            mem2[ma] <= Mem_Write_data[23:16];
            mem3[ma] <= Mem_Write_data[31:24];
        end else if (Mem_MemWrite == 2'b10) begin
            mem0[ma] <= Mem_Write_data[7:0];
        end
    end

    assign Mem_Read_data = (Mem_MemRead == 2'b01) ? {mem3[ma], mem2[ma], mem1[ma], mem0[ma]} :
                           (Mem_MemRead == 2'b10) ? {24'h0, mem0[ma]} : 32'h0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Latency is counted so that a word op accepted at edge E reports 2.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && Rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got Rsp_valid=1 expected no response");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_data"}, Rsp_data, mon_e.data);
                chk({mon_e.name, "_err"}, 32'(Rsp_err), 32'(mon_e.err));
                chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(string n, logic [2:0] op, logic [31:0] addr, logic [31:0] wd,
                         logic [31:0] edata, logic eerr, int lat, bit expect_rsp, bit hold);
        int k = 0;
        @(negedge clk);
        while (Req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({n, "_ready_wait"}, 32'(Req_ready), 32'd1);
        if (Req_ready !== 1'b1) return;
        Req_valid = 1'b1;
        Req_op    = op;
        Req_addr  = addr;
        Req_wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) Req_valid = 1'b0;
        if (expect_rsp) sb.push_back('{name: n, data: edata, err: eerr, acc: cyc, lat: lat});
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int low;
        Req_valid = 1'b0;
        Req_op    = 3'b000;
        Req_addr  = '0;
        Req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00; mem1[i] = 8'h00; mem2[i] = 8'h00; mem3[i] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(Req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(Rsp_valid), 32'd0);
        chk("rst_rsp_data", Rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(Rsp_err), 32'd0);
        chk("rst_addr", Mem_Address, 32'd0);
        chk("rst_wdata", Mem_Write_data, 32'd0);
        chk("rst_strobes", {28'h0, Mem_MemWrite, Mem_MemRead}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("sw10", SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 1'b0);
        chk("sw10_memwrite", 32'(Mem_MemWrite), 32'd1);
        chk("sw10_addr", Mem_Address, 32'h10);
        chk("sw10_wdata", Mem_Write_data, 32'hDEADBEEF);
        chk("sw10_ready_busy", 32'(Req_ready), 32'd0);
        @(posedge clk); #1;
        chk("sw10_memwrite_off", 32'(Mem_MemWrite), 32'd0);

        issue("lw10", LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0);
        chk("lw10_memread", 32'(Mem_MemRead), 32'd1);

        issue("sb5", SB, 32'h5, 32'h00000080, 32'h0, 1'b0, 2, 1'b1, 1'b0);
        chk("sb5_memwrite", 32'(Mem_MemWrite), 32'd2);
        chk("sb5_wdata", Mem_Write_data, 32'h80);
        issue("lb5", LB, 32'h5, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1, 1'b0);
        chk("lb5_memread", 32'(Mem_MemRead), 32'd2);
        issue("lbu5", LBU, 32'h5, 32'h0, 32'h00000080, 1'b0, 2, 1'b1, 1'b0);
        chk("lbu5_memread", 32'(Mem_MemRead), 32'd2);

        issue("sh20", SH, 32'h20, 32'h0000F00D, 32'h0, 1'b0, 3, 1'b1, 1'b0);
        chk("sh20_lo_addr", Mem_Address, 32'h20);
        chk("sh20_lo_wdata", Mem_Write_data, 32'h0D);
        chk("sh20_lo_memwrite", 32'(Mem_MemWrite), 32'd2);
        @(posedge clk); #1;
        chk("sh20_hi_addr", Mem_Address, 32'h21);
        chk("sh20_hi_wdata", Mem_Write_data, 32'hF0);
        chk("sh20_hi_memwrite", 32'(Mem_MemWrite), 32'd2);
        @(posedge clk); #1;
        chk("sh20_memwrite_off", 32'(Mem_MemWrite), 32'd0);
        chk("sh20_mem_lo", 32'(mem0[8'h20]), 32'h0D);
        chk("sh20_mem_hi", 32'(mem0[8'h21]), 32'hF0);

        issue("lh20", LH, 32'h20, 32'h0, 32'hFFFFF00D, 1'b0, 3, 1'b1, 1'b0);
        issue("lhu20", LHU, 32'h20, 32'h0, 32'h0000F00D, 1'b0, 3, 1'b1, 1'b0);

        issue("sh254", SH, 32'd254, 32'h0000AB12, 32'h0, 1'b0, 3, 1'b1, 1'b0);
        issue("lhu254", LHU, 32'd254, 32'h0, 32'h0000AB12, 1'b0, 3, 1'b1, 1'b0);
        issue("lb255", LB, 32'd255, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 1'b1, 1'b0);

        issue("sh255_err", SH, 32'd255, 32'h00005566, 32'h0, 1'b1, 1, 1'b1, 1'b0);
        chk("sh255_strobes_resp", {28'h0, Mem_MemWrite, Mem_MemRead}, 32'd0);
        @(posedge clk); #1;
        chk("sh255_strobes_idle", {28'h0, Mem_MemWrite, Mem_MemRead}, 32'd0);
        chk("sh255_mem255", 32'(mem0[8'hFF]), 32'hAB);
        chk("sh255_mem0", 32'(mem0[8'h00]), 32'h00);

        issue("lw256_err", LW, 32'd256, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
        chk("lw256_strobes", {28'h0, Mem_MemWrite, Mem_MemRead}, 32'd0);
        issue("sbmax_err", SB, 32'hFFFFFFFF, 32'h11, 32'h0, 1'b1, 1, 1'b1, 1'b0);

        // Req_valid held high: the LW must wait for the SW to return to IDLE.
        issue("b2b_sw", SW, 32'h40, 32'h12345678, 32'h0, 1'b0, 2, 1'b1, 1'b1);
        Req_op   = LW;
        Req_addr = 32'h40;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            if (Req_ready === 1'b1) break;
            low++;
            @(posedge clk); #1;
        end
        chk("b2b_ready_low", 32'(low), 32'd2);
        @(posedge clk); #1;
        sb.push_back('{name: "b2b_lw", data: 32'h12345678, err: 1'b0, acc: cyc, lat: 2});
        Req_valid = 1'b0;
        chk("b2b_lw_memread", 32'(Mem_MemRead), 32'd1);
        chk("b2b_lw_addr", Mem_Address, 32'h40);

        drain();
        issue("sw3_abort", SW, 32'h3, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        chk("sw3_memwrite", 32'(Mem_MemWrite), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("sw3_rst_strobes", {28'h0, Mem_MemWrite, Mem_MemRead}, 32'd0);
        chk("sw3_rst_addr", Mem_Address, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("sw3_mem_unchanged", {mem3[3], mem2[3], mem1[3], mem0[3]}, 32'h0);
        chk("sw3_ready_after", 32'(Req_ready), 32'd1);

        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
